// File: rtl/fifo_param.sv
// fifo_param
// Parametrised single-clock FIFO with a registered read port, run-time
// almost-full / almost-empty thresholds, a sticky overflow/underflow error
// and a hysteretic pause request for the upstream producer.
//
// Ports:
//   clk              - single clock, all state changes on the rising edge
//   reset_L          - asynchronous active-low reset
//   write / read     - push / pop requests
//   buff_in          - push data (DATA_SIZE bits)
//   umb_almost_full  - almost-full flag and pause-set threshold (count)
//   umb_almost_empty - almost-empty flag and pause-clear threshold (count)
//   err_clr          - clears the sticky error flag
//   buff_out         - registered pop data, loads only on an accepted read
//   valid_out        - buff_out was updated by the last edge
//   data_count       - number of stored words, 0..DEPTH
//   fifo_full, fifo_empty, almost_full, almost_empty - status flags
//   pause            - registered flow-control request (hysteretic)
//   error            - sticky overflow/underflow indicator

module fifo_param #(
  parameter int DATA_SIZE = 4,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] buff_in,
  input  logic [ADDR_SIZE:0]   umb_almost_full,
  input  logic [ADDR_SIZE:0]   umb_almost_empty,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] buff_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 pause,
  output logic                 error
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_COUNT = {1'b1, {ADDR_SIZE{1'b0}}};

  typedef enum logic {
    IDLE   = 1'b0,
    PAUSED = 1'b1
  } pause_state_t;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   next_count;
  logic                 rd_ok;
  logic                 wr_ok;
  logic                 overflow;
  logic                 underflow;
  pause_state_t         pause_state;
  pause_state_t         pause_next;

  // Status flags are pure functions of the current occupancy and thresholds,
  // so a threshold change is visible in the same cycle.
  assign fifo_full    = (data_count == FULL_COUNT);
  assign fifo_empty   = (data_count == '0);
  assign almost_full  = (data_count >= umb_almost_full);
  assign almost_empty = (data_count <= umb_almost_empty);

  // A read on full frees a slot in the same edge, so a write alongside it is
  // still accepted. A read on empty is always rejected, even with a write.
  assign rd_ok     = read && !fifo_empty;
  assign wr_ok     = write && (!fifo_full || rd_ok);
  assign overflow  = write && fifo_full && !read;
  assign underflow = read && fifo_empty;

  // Occupancy after this edge; shared by the count register and the pause
  // evaluation so pause reacts in the same cycle the count crosses a threshold.
  always_comb begin
    next_count = data_count;
    case ({wr_ok, rd_ok})
      2'b10:   next_count = data_count + (ADDR_SIZE+1)'(1);
      2'b01:   next_count = data_count - (ADDR_SIZE+1)'(1);
      default: next_count = data_count;
    endcase
  end

  // Pause hysteresis: set at or above the almost-full threshold, release at
  // or below the almost-empty threshold. Testing the set condition first makes
  // PAUSED win when the thresholds overlap.
  always_comb begin
    pause_next = pause_state;
    if (next_count >= umb_almost_full) begin
      pause_next = PAUSED;
    end else if (next_count <= umb_almost_empty) begin
      pause_next = IDLE;
    end
  end

  assign pause = (pause_state == PAUSED);

  // Storage array is deliberately not reset; buff_out only ever loads from a
  // slot that was written, so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= buff_in;
    end
  end

  // Pointers, count, read port, error and pause state. Pointers are exactly
  // ADDR_SIZE bits so they wrap DEPTH-1 -> 0 without extra logic.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      buff_out    <= '0;
      valid_out   <= 1'b0;
      error       <= 1'b0;
      pause_state <= IDLE;
    end else begin
      data_count  <= next_count;
      valid_out   <= rd_ok;
      pause_state <= pause_next;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (rd_ok) begin
        buff_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      if (overflow || underflow) begin
        error <= 1'b1;
      end else if (err_clr) begin
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
// Self-checking bench for fifo_param (DATA_SIZE 4, ADDR_SIZE 3). A table of
// {inputs, expected outputs} records drives the fill / overflow / drain /
// underflow sequence; hand-written sequences cover simultaneous operations,
// pointer wrap-around and asynchronous reset. Popped data is checked against
// a scoreboard queue filled when accepted reads are driven.

module tb_fifo_param;

  logic       clk;
  logic       reset_L;
  logic       write;
  logic       read;
  logic [3:0] buff_in;
  logic [3:0] umb_almost_full;
  logic [3:0] umb_almost_empty;
  logic       err_clr;
  logic [3:0] buff_out;
  logic       valid_out;
  logic [3:0] data_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       pause;
  logic       error;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [3:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       pause;
    logic       err;
    logic       valid;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] store_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] last_out;
  int         num_vectors;
  int         num_compares;
  int         num_miscompares;

  fifo_param #(
    .DATA_SIZE(4),
    .ADDR_SIZE(3)
  ) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .write            (write),
    .read             (read),
    .buff_in          (buff_in),
    .umb_almost_full  (umb_almost_full),
    .umb_almost_empty (umb_almost_empty),
    .err_clr          (err_clr),
    .buff_out         (buff_out),
    .valid_out        (valid_out),
    .data_count       (data_count),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .pause            (pause),
    .error            (error)
  );

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input int wr, input int rd, input int clr,
                                 input int din, input int cnt, input int full,
                                 input int empty, input int af, input int ae,
                                 input int pz, input int err, input int valid);
    vec_t v;
    v.wr    = (wr != 0);
    v.rd    = (rd != 0);
    v.clr   = (clr != 0);
    v.din   = 4'(din);
    v.cnt   = 4'(cnt);
    v.full  = (full != 0);
    v.empty = (empty != 0);
    v.af    = (af != 0);
    v.ae    = (ae != 0);
    v.pause = (pz != 0);
    v.err   = (err != 0);
    v.valid = (valid != 0);
    return v;
  endfunction

  task automatic compareField(input string name, input int act, input int exp);
    num_compares++;
    if (act != exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and advance the queue model:
  // an accepted read moves the oldest stored word onto the expected-output queue.
  task automatic applyStimulus(input vec_t v);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    write   = v.wr;
    read    = v.rd;
    err_clr = v.clr;
    buff_in = v.din;
    rd_ok = v.rd && (store_q.size() != 0);
    wr_ok = v.wr && ((store_q.size() != 8) || rd_ok);
    if (rd_ok) exp_q.push_back(store_q.pop_front());
    if (wr_ok) store_q.push_back(v.din);
    num_vectors++;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    logic [3:0] exp_data;
    compareField({tag, ".count"}, int'(data_count), int'(v.cnt));
    compareField({tag, ".full"}, int'(fifo_full), int'(v.full));
    compareField({tag, ".empty"}, int'(fifo_empty), int'(v.empty));
    compareField({tag, ".almost_full"}, int'(almost_full), int'(v.af));
    compareField({tag, ".almost_empty"}, int'(almost_empty), int'(v.ae));
    compareField({tag, ".pause"}, int'(pause), int'(v.pause));
    compareField({tag, ".error"}, int'(error), int'(v.err));
    compareField({tag, ".valid_out"}, int'(valid_out), int'(v.valid));
    if (v.valid) begin
      if (exp_q.size() == 0) begin
        num_compares++;
        num_miscompares++;
        $display("[TB] FAIL %s.scoreboard: got empty queue, expected a word", tag);
      end else begin
        exp_data = exp_q.pop_front();
        compareField({tag, ".buff_out"}, int'(buff_out), int'(exp_data));
        last_out = exp_data;
      end
    end else begin
      compareField({tag, ".buff_out_hold"}, int'(buff_out), int'(last_out));
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(tag, v);
  endtask

  task automatic checkReset(input string tag);
    num_vectors++;
    compareField({tag, ".count"}, int'(data_count), 0);
    compareField({tag, ".empty"}, int'(fifo_empty), 1);
    compareField({tag, ".full"}, int'(fifo_full), 0);
    compareField({tag, ".pause"}, int'(pause), 0);
    compareField({tag, ".error"}, int'(error), 0);
    compareField({tag, ".valid_out"}, int'(valid_out), 0);
    compareField({tag, ".buff_out"}, int'(buff_out), 0);
  endtask

  initial begin
    num_vectors      = 0;
    num_compares     = 0;
    num_miscompares  = 0;
    last_out         = 4'd0;
    reset_L          = 1'b0;
    write            = 1'b0;
    read             = 1'b0;
    err_clr          = 1'b0;
    buff_in          = 4'd0;
    umb_almost_full  = 4'd6;
    umb_almost_empty = 4'd3;

    // Vector table: wr rd clr din | cnt full empty af ae pause err valid
    // Fill with 3..10 under thresholds 6/3.
    tbl.push_back(mkVec(1,0,0, 3, 1,0,0,0,1,0,0,0));
    tbl.push_back(mkVec(1,0,0, 4, 2,0,0,0,1,0,0,0));
    tbl.push_back(mkVec(1,0,0, 5, 3,0,0,0,1,0,0,0));
    tbl.push_back(mkVec(1,0,0, 6, 4,0,0,0,0,0,0,0));
    tbl.push_back(mkVec(1,0,0, 7, 5,0,0,0,0,0,0,0));
    tbl.push_back(mkVec(1,0,0, 8, 6,0,0,1,0,1,0,0));
    tbl.push_back(mkVec(1,0,0, 9, 7,0,0,1,0,1,0,0));
    tbl.push_back(mkVec(1,0,0,10, 8,1,0,1,0,1,0,0));
    // Overflow: 11 is dropped.
    tbl.push_back(mkVec(1,0,0,11, 8,1,0,1,0,1,1,0));
    // Drain: pause holds through 5 and 4, releases at 3.
    tbl.push_back(mkVec(0,1,0, 0, 7,0,0,1,0,1,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 6,0,0,1,0,1,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 5,0,0,0,0,1,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 4,0,0,0,0,1,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 3,0,0,0,1,0,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 2,0,0,0,1,0,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 1,0,0,0,1,0,1,1));
    tbl.push_back(mkVec(0,1,0, 0, 0,0,1,0,1,0,1,1));
    // Clear, underflow (buff_out holds 10), clear, clear+underflow, clear.
    tbl.push_back(mkVec(0,0,1, 0, 0,0,1,0,1,0,0,0));
    tbl.push_back(mkVec(0,1,0, 0, 0,0,1,0,1,0,1,0));
    tbl.push_back(mkVec(0,0,1, 0, 0,0,1,0,1,0,0,0));
    tbl.push_back(mkVec(0,1,1, 0, 0,0,1,0,1,0,1,0));
    tbl.push_back(mkVec(0,0,1, 0, 0,0,1,0,1,0,0,0));

    #12;
    checkReset("reset_init");
    @(negedge clk);
    reset_L = 1'b1;

    $display("[TB] table sequence: fill, overflow, drain, underflow");
    foreach (tbl[i]) begin
      runVec($sformatf("tbl[%0d]", i), tbl[i]);
    end

    $display("[TB] full with simultaneous write+read");
    for (int i = 1; i <= 8; i++) begin
      runVec("fill2", mkVec(1,0,0, i-1, i, int'(i == 8), 0,
                            int'(i >= 6), int'(i <= 3), int'(i >= 6), 0, 0));
    end
    runVec("full_wr_rd", mkVec(1,1,0, 8, 8,1,0,1,0,1,0,1));
    for (int c = 7; c >= 0; c--) begin
      runVec("drain2", mkVec(0,1,0, 0, c, 0, int'(c == 0),
                             int'(c >= 6), int'(c <= 3), int'(c > 3), 0, 1));
    end

    $display("[TB] empty with simultaneous write+read");
    runVec("empty_wr_rd", mkVec(1,1,0, 10, 1,0,0,0,1,0,1,0));
    runVec("empty_clr",   mkVec(0,0,1,  0, 1,0,0,0,1,0,0,0));

    $display("[TB] wrap-around at count 4");
    runVec("prefill", mkVec(1,0,0, 11, 2,0,0,0,1,0,0,0));
    runVec("prefill", mkVec(1,0,0, 12, 3,0,0,0,1,0,0,0));
    runVec("prefill", mkVec(1,0,0, 13, 4,0,0,0,0,0,0,0));
    for (int i = 0; i < 20; i++) begin
      runVec($sformatf("wrap[%0d]", i),
             mkVec(1,1,0, (14 + i) % 16, 4,0,0,0,0,0,0,1));
    end

    $display("[TB] threshold change and asynchronous reset mid-stream");
    umb_almost_full = 4'd5;
    runVec("to_five", mkVec(1,0,0, 2, 5,0,0,1,0,1,0,0));
    #2;
    reset_L = 1'b0;
    #1;
    checkReset("reset_async");
    @(negedge clk);
    write   = 1'b1;
    buff_in = 4'd7;
    @(posedge clk);
    #1;
    checkReset("reset_held");
    @(negedge clk);
    reset_L = 1'b1;
    write   = 1'b0;
    store_q.delete();
    exp_q.delete();
    last_out        = 4'd0;
    umb_almost_full = 4'd6;
    runVec("post_reset_wr", mkVec(1,0,0, 5, 1,0,0,0,1,0,0,0));
    runVec("post_reset_rd", mkVec(0,1,0, 0, 0,0,1,0,1,0,0,1));

    compareField("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the fixed 4-bit/4-entry FIFO in the FIFO test setup. It has configurable width and depth, run-time almost-full/almost-empty thresholds, a registered read port with a valid strobe, sticky overflow/underflow error with clear, and a hysteretic `pause` output for upstream flow control. It sits between a producer and a consumer in the same clock domain and is checked against its structural twin by the existing FIFO bench style.

## Interface
- `DATA_SIZE`, default 4: data word width in bits.
- `ADDR_SIZE`, default 3: address width; DEPTH = 2**ADDR_SIZE entries (8).
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset_L`  in  1: reset, asynchronous, active-low.
- `write`  in  1: push request.
- `read`  in  1: pop request.
- `buff_in`  in  DATA_SIZE: push data.
- `umb_almost_full`  in  ADDR_SIZE+1: almost-full / pause-set threshold (count).
- `umb_almost_empty`  in  ADDR_SIZE+1: almost-empty / pause-clear threshold (count).
- `err_clr`  in  1: clears sticky `error`.
- `buff_out`  out  DATA_SIZE: registered pop data.
- `valid_out`  out  1: `buff_out` updated this cycle.
- `data_count`  out  ADDR_SIZE+1: stored words, 0..DEPTH.
- `fifo_full`, `fifo_empty`, `almost_full`, `almost_empty`  out  1 each: status flags.
- `pause`  out  1: registered flow-control request to producer.
- `error`  out  1: sticky overflow/underflow indicator.

## Operation
- Storage: DEPTH x DATA_SIZE array. `wr_ptr` and `rd_ptr` are ADDR_SIZE bits and wrap DEPTH-1 -> 0 naturally. Occupancy is tracked by `data_count` (ADDR_SIZE+1 bits), not by pointer comparison.
- Read accepted (`rd_ok`): `read && !fifo_empty`.
- Write accepted (`wr_ok`): `write && (!fifo_full || rd_ok)`. When full, a simultaneous read frees the slot and both operations proceed.
- Read while empty with simultaneous write: the read is rejected (underflow), the write is accepted, and count goes 0 -> 1.
- Count update: +1 on `wr_ok` only; -1 on `rd_ok` only; unchanged on both or neither.
- Overflow: `write && fifo_full && !read`. The word is dropped, nothing else changes, and `error` is set.
- Underflow: `read && fifo_empty`. The read is dropped, `buff_out` holds its value, `valid_out` = 0, and `error` is set.
- `error` stays set until `err_clr` or reset. If `err_clr` and a new error occur in the same cycle, the set wins and `error` stays 1.
- Flags are combinational from `data_count` and the thresholds:
  - `fifo_full` = (count == DEPTH)
  - `fifo_empty` = (count == 0)
  - `almost_full` = (count >= umb_almost_full)
  - `almost_empty` = (count <= umb_almost_empty)
- `pause` is a two-state register, IDLE (0) / PAUSED (1), evaluated on the next-state count:
  - IDLE -> PAUSED when next count >= umb_almost_full.
  - PAUSED -> IDLE when next count <= umb_almost_empty.
  - If both conditions hold (misprogrammed thresholds), PAUSED wins.
- Thresholds may change at any time and take effect on the current cycle's flags and the next `pause` evaluation.
- Memory contents are not reset. Stale data is never observable, because `buff_out` only loads on `rd_ok`.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - `data_count`, `wr_ptr`, `rd_ptr`, `buff_out`, `valid_out`, `error`, `pause` are 0.
  - Hence `fifo_empty` = 1 and `fifo_full` = 0; `almost_empty`/`almost_full` follow the thresholds (with count 0).
- Reset mid-operation: all of the above take effect immediately, independent of `clk`, and in-flight data is discarded.
- Write latency: a word presented with `write` at edge N is counted from edge N. It can be popped with `read` at edge N+1 and appears on `buff_out` after edge N+1.
- Read latency: 1 cycle. After an edge with `rd_ok`, `buff_out` = mem[old rd_ptr] and `valid_out` = 1 for that single cycle.
- Status flags change in the same cycle as `data_count`. `pause` and `error` are registered and also update at that edge.
- Sustained simultaneous read+write at any non-empty count:
  - throughput is 1 word/cycle;
  - count and flags stay constant;
  - `valid_out` stays high.

## Test plan
- **Reset:** assert `reset_L`=0 mid-stream with count 5 -> immediately count 0, `fifo_empty`=1, `pause`=0, `error`=0, `valid_out`=0, `buff_out`=0.
- **Fill and thresholds:** DATA 4, ADDR 3, thresholds 6/3; write 3,4,...,10 on 8 cycles ->
  - count steps 1..8;
  - `almost_full` from count 6;
  - `pause`=1 after the edge reaching 6;
  - `fifo_full`=1 at 8.
- **Overflow, then drain:** continue from the full state.
  - 9th write (value 11) -> dropped, count stays 8, `error`=1.
  - Read 8 times -> `buff_out` = 3..10 in order, one cycle after each read.
  - `pause` clears after the edge reaching count 3.
  - `fifo_empty` at 0.
- **Underflow and clear:** read on empty -> `error`=1, `buff_out` holds 10, `valid_out`=0. `err_clr` pulse -> `error`=0. `err_clr` together with a new underflow -> `error` stays 1.
- **Simultaneous operations:**
  - Full plus write+read -> both accepted, count stays 8, no error.
  - Empty plus write+read -> write accepted, count 1, `error`=1.
- **Wrap-around:** 20 cycles of simultaneous read+write at count 4 with incrementing data -> output sequence contiguous across pointer wrap, count constant at 4, `valid_out`=1 throughout.
